fp_booth_seq: RTL and testbench

FP_BOOTH_SEQ -- requirements
Module: fp_booth_seq

---
 rtl/fp_mul_pkg.sv | 47 ++++
 rtl/booth_digit_enc.sv | 30 +++
 rtl/fp_booth_seq.sv | 135 +++++++++++++
 tb/tb_fp_booth_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// -----------------------------------------------------------------------------
// fp_mul_pkg
// Shared types and constants for the single-precision significand multiplier.
//   state_e  : sequencer states (IDLE, RUN, DONE)
//   booth_e  : radix-4 Booth digit values {0, +M, +2M, -M, -2M}
//   SIG_W / PROD_W / DIGITS / ACC_W : significand, product, digit count and
//              accumulator widths
//   booth_pp : partial product for one Booth digit at accumulator width
// -----------------------------------------------------------------------------
package fp_mul_pkg;

    localparam int SIG_W  = 24;
    localparam int PROD_W = 48;
    localparam int DIGITS = 13;
    // Two guard bits above the product so negative partial sums stay representable.
    localparam int ACC_W  = 50;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        B_ZERO = 3'd0,
        B_P1   = 3'd1,
        B_P2   = 3'd2,
        B_M1   = 3'd3,
        B_M2   = 3'd4
    } booth_e;

    // Scale an already-aligned multiplicand by a Booth digit (two's complement).
    function automatic logic [ACC_W-1:0] booth_pp(input booth_e digit,
                                                  input logic [ACC_W-1:0] mcand);
        logic [ACC_W-1:0] pp;
        case (digit)
            B_ZERO:  pp = {ACC_W{1'b0}};
            B_P1:    pp = mcand;
            B_P2:    pp = mcand << 1;
            B_M1:    pp = ~mcand + {{(ACC_W-1){1'b0}}, 1'b1};
            B_M2:    pp = ~(mcand << 1) + {{(ACC_W-1){1'b0}}, 1'b1};
            default: pp = {ACC_W{1'b0}};
        endcase
        return pp;
    endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// -----------------------------------------------------------------------------
// booth_digit_enc
// Combinational radix-4 Booth recoder.
//   slice_i [2:0] : multiplier bits {y[2i+1], y[2i], y[2i-1]}
//   digit_o       : recoded digit (booth_e)
// -----------------------------------------------------------------------------
module booth_digit_enc
    import fp_mul_pkg::*;
(
    input  logic [2:0] slice_i,
    output booth_e     digit_o
);

    // Standard radix-4 recoding table.
    always_comb begin
        digit_o = B_ZERO;
        case (slice_i)
            3'b000:  digit_o = B_ZERO;
            3'b001:  digit_o = B_P1;
            3'b010:  digit_o = B_P1;
            3'b011:  digit_o = B_P2;
            3'b100:  digit_o = B_M2;
            3'b101:  digit_o = B_M1;
            3'b110:  digit_o = B_M1;
            3'b111:  digit_o = B_ZERO;
            default: digit_o = B_ZERO;
        endcase
    end

endmodule

// File: rtl/fp_booth_seq.sv
// -----------------------------------------------------------------------------
// fp_booth_seq
// Sequential radix-4 Booth multiplier for 24-bit significands, one digit per
// clock, 13 cycles from accept to result.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   frc_X, hid_X          : multiplicand fraction and hidden bit
//   frc_Y, hid_Y          : multiplier fraction and hidden bit
//   sign_in, r_mode_in    : sideband carried alongside the operation
//   out_valid / out_ready : result handshake (valid only in DONE)
//   frc_Z_full            : 48-bit unsigned product
//   sign_Z, r_mode        : sideband captured at accept
// -----------------------------------------------------------------------------
module fp_booth_seq #(
    parameter int DIGITS = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [22:0] frc_X,
    input  logic [22:0] frc_Y,
    input  logic        hid_X,
    input  logic        hid_Y,
    input  logic        sign_in,
    input  logic [2:0]  r_mode_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] frc_Z_full,
    output logic        sign_Z,
    output logic [2:0]  r_mode
);

    import fp_mul_pkg::*;

    localparam logic [3:0] LAST_CNT = 4'(DIGITS - 1);

    state_e             state_q,  state_d;
    logic [3:0]         cnt_q,    cnt_d;
    // Multiplicand pre-shifted by 2*cnt; multiplier shifted right by 2 per digit
    // so the current Booth window is always mplier_q[2:0].
    logic [ACC_W-1:0]   mcand_q,  mcand_d;
    logic [26:0]        mplier_q, mplier_d;
    logic [ACC_W-1:0]   acc_q,    acc_d;
    logic [PROD_W-1:0]  prod_q,   prod_d;
    logic               sign_q,   sign_d;
    logic [2:0]         rmode_q,  rmode_d;
    booth_e             digit_s;

    booth_digit_enc u_enc (
        .slice_i (mplier_q[2:0]),
        .digit_o (digit_s)
    );

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign frc_Z_full = prod_q;
    assign sign_Z     = sign_q;
    assign r_mode     = rmode_q;

    // Next-state and datapath update for the accept / iterate / hand-off sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        sign_d   = sign_q;
        rmode_d  = rmode_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = {26'd0, hid_X, frc_X};
                    // Unsigned multiplier: two zero bits on top, implicit 0 below bit 0.
                    mplier_d = {2'b00, hid_Y, frc_Y, 1'b0};
                    acc_d    = {ACC_W{1'b0}};
                    cnt_d    = 4'd0;
                    sign_d   = sign_in;
                    rmode_d  = r_mode_in;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_d    = acc_q + booth_pp(digit_s, mcand_q);
                mcand_d  = mcand_q << 2;
                mplier_d = mplier_q >> 2;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    // Final sum is non-negative and below 2^48, so the low 48 bits are exact.
                    prod_d  = acc_d[PROD_W-1:0];
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            mcand_q  <= {ACC_W{1'b0}};
            mplier_q <= 27'd0;
            acc_q    <= {ACC_W{1'b0}};
            prod_q   <= {PROD_W{1'b0}};
            sign_q   <= 1'b0;
            rmode_q  <= 3'b000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            sign_q   <= sign_d;
            rmode_q  <= rmode_d;
        end
    end

endmodule

// File: tb/tb_fp_booth_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_booth_seq
// Scoreboard bench: the driver pushes the expected product/sideband and the
// accept cycle when an operand pair is accepted; a negedge monitor pops and
// compares on every output handshake and checks accept-to-valid latency.
// -----------------------------------------------------------------------------
module tb_fp_booth_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] frc_X;
    logic [22:0] frc_Y;
    logic        hid_X;
    logic        hid_Y;
    logic        sign_in;
    logic [2:0]  r_mode_in;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] frc_Z_full;
    logic        sign_Z;
    logic [2:0]  r_mode;

    typedef struct {
        logic [47:0] prod;
        logic        sgn;
        logic [2:0]  rm;
    } exp_t;

    exp_t sb[$];
    int   acc_cyc_q[$];
    int   cyc;
    int   errors;
    int   checks;
    logic prev_ov;
    logic rnd_ready;

    fp_booth_seq #(.DIGITS(13)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .frc_X      (frc_X),
        .frc_Y      (frc_Y),
        .hid_X      (hid_X),
        .hid_Y      (hid_Y),
        .sign_in    (sign_in),
        .r_mode_in  (r_mode_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frc_Z_full (frc_Z_full),
        .sign_Z     (sign_Z),
        .r_mode     (r_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Random backpressure, active only in the stress phase.
    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: latency on each rising out_valid, scoreboard compare on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov <= 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (acc_cyc_q.size() == 0) begin
                    chk("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    chk("latency", 64'(cyc - acc_cyc_q[0]), 64'd14);
                    acc_cyc_q.delete(0);
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    chk("product", 64'(frc_Z_full), 64'(sb[0].prod));
                    chk("sign_Z", 64'(sign_Z), 64'(sb[0].sgn));
                    chk("r_mode", 64'(r_mode), 64'(sb[0].rm));
                    sb.delete(0);
                end
            end
            prev_ov <= out_valid;
        end
    end

    // Offer one operand pair; entered and left at posedge+1.
    task automatic issue(input logic [23:0] x, input logic [23:0] y, input logic s,
                         input logic [2:0] rm, input logic [47:0] exp_prod);
        exp_t e;
        int   n;
        hid_X     = x[23];
        frc_X     = x[22:0];
        hid_Y     = y[23];
        frc_Y     = y[22:0];
        sign_in   = s;
        r_mode_in = rm;
        in_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            e.prod = exp_prod;
            e.sgn  = s;
            e.rm   = rm;
            sb.push_back(e);
            acc_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: {X significand, Y significand, hand-computed product}.
    logic [23:0] dx [9] = '{24'h800000, 24'hFFFFFF, 24'h000001, 24'h000000, 24'h800000,
                            24'hC00000, 24'h000003, 24'hFFFFFF, 24'h800000};
    logic [23:0] dy [9] = '{24'hC90FDB, 24'hFFFFFF, 24'h000001, 24'hABCDEF, 24'h800000,
                            24'hC00000, 24'h000005, 24'h000001, 24'hFFFFFF};
    logic [47:0] dz [9] = '{48'h6487ED800000, 48'hFFFFFE000001, 48'h000000000001,
                            48'h000000000000, 48'h400000000000, 48'h900000000000,
                            48'h00000000000F, 48'h000000FFFFFF, 48'h7FFFFF800000};

    initial begin
        int          n;
        int          cntv;
        logic [23:0] rx;
        logic [23:0] ry;
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        frc_X     = 23'd0;
        frc_Y     = 23'd0;
        hid_X     = 1'b0;
        hid_Y     = 1'b0;
        sign_in   = 1'b0;
        r_mode_in = 3'b000;
        out_ready = 1'b1;
        rnd_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_frc_Z_full", 64'(frc_Z_full), 64'd0);
        chk("rst_sign_Z", 64'(sign_Z), 64'd0);
        chk("rst_r_mode", 64'(r_mode), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            issue(dx[i], dy[i], 1'(i), 3'(i), dz[i]);
        end
        drain();

        // Backpressure: result must sit unchanged while out_ready is low.
        out_ready = 1'b0;
        issue(24'hC00000, 24'hC00000, 1'b1, 3'b011, 48'h900000000000);
        n = 0;
        while (!out_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_prod", 64'(frc_Z_full), 64'h900000000000);
            chk("bp_hold_sign", 64'(sign_Z), 64'd1);
            chk("bp_hold_rmode", 64'(r_mode), 64'd3);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        chk("bp_valid_after", 64'(out_valid), 64'd0);
        drain();

        // Reset at cnt=6 with a second operand pair pending.
        issue(24'hFFFFFF, 24'hFFFFFF, 1'b0, 3'b001, 48'hFFFFFE000001);
        repeat (6) @(posedge clk);
        #1;
        hid_X    = 1'b1;
        frc_X    = 23'h123456;
        hid_Y    = 1'b1;
        frc_Y    = 23'h654321;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_frc_Z_full", 64'(frc_Z_full), 64'd0);
        chk("mid_rst_sign_Z", 64'(sign_Z), 64'd0);
        chk("mid_rst_r_mode", 64'(r_mode), 64'd0);
        sb.delete();
        acc_cyc_q.delete();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cntv = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) cntv++;
        end
        chk("no_valid_after_reset", 64'(cntv), 64'd0);
        @(posedge clk);
        #1;
        issue(24'h800000, 24'h800000, 1'b1, 3'b100, 48'h400000000000);
        drain();

        // Stress with random idle gaps and random backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rx = 24'($urandom);
            ry = 24'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            issue(rx, ry, 1'($urandom), 3'($urandom), {24'd0, rx} * {24'd0, ry});
        end
        drain();
        rnd_ready = 1'b0;
        #2;
        out_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
